// File: rtl/branch_predictor.sv
// Purpose : direct-mapped BTB with per-entry saturating direction counters and a mispredict statistic.
// Latency : lookup and mispredict flag are combinational; table and statistic update on the next clk_i edge.
// Backpressure: none; an update may arrive every cycle and is never stalled.
//
// Ports:
//   clk_i, rst_i                 clock, asynchronous active-high reset
//   pc_i -> pred_taken_o,        IF-stage lookup: predicted direction and next PC
//           pred_target_o
//   upd_*_i -> mispredict_o      ID-stage resolved branch, actual vs predicted outcome
//   clear_i                      synchronous invalidate of the whole table
//   mispred_cnt_o                saturating mispredict count since reset
module branch_predictor #(
  parameter int ADDR_W  = 32,
  parameter int ENTRIES = 16,
  parameter int CNT_W   = 2,
  parameter int STAT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ADDR_W-1:0] pc_i,
  output logic              pred_taken_o,
  output logic [ADDR_W-1:0] pred_target_o,
  input  logic              upd_valid_i,
  input  logic [ADDR_W-1:0] upd_pc_i,
  input  logic              upd_taken_i,
  input  logic [ADDR_W-1:0] upd_target_i,
  input  logic              upd_pred_taken_i,
  input  logic [ADDR_W-1:0] upd_pred_target_i,
  output logic              mispredict_o,
  input  logic              clear_i,
  output logic [STAT_W-1:0] mispred_cnt_o
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = ADDR_W - IDX_W - 2;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  // Weakly taken is the MSB alone; weakly not-taken is one below it.
  localparam logic [CNT_W-1:0] CNT_WT  = CNT_W'(1) << (CNT_W - 1);
  localparam logic [CNT_W-1:0] CNT_WNT = CNT_WT - CNT_W'(1);
  localparam logic [STAT_W-1:0] STAT_MAX = {STAT_W{1'b1}};

  typedef struct packed {
    logic              valid;
    logic [TAG_W-1:0]  tag;
    logic [ADDR_W-1:0] target;
    logic [CNT_W-1:0]  cnt;
  } entry_t;

  entry_t            tbl_q [ENTRIES];
  entry_t            tbl_d [ENTRIES];
  logic [STAT_W-1:0] mispred_cnt_q;
  logic [STAT_W-1:0] mispred_cnt_d;

  // The byte offset of a PC never reaches the index or the tag.
  logic unused_pc_lsbs;
  assign unused_pc_lsbs = ^{pc_i[1:0], upd_pc_i[1:0]};

  // ---------------------------------------------------------------- lookup
  logic [IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0] lk_tag;
  entry_t           lk_ent;
  logic             lk_hit;

  assign lk_idx = pc_i[IDX_W+1:2];
  assign lk_tag = pc_i[ADDR_W-1:IDX_W+2];
  assign lk_ent = tbl_q[lk_idx];
  assign lk_hit = lk_ent.valid && (lk_ent.tag == lk_tag);

  // Reads tbl_q only, so a same-cycle update to this index is not visible yet.
  assign pred_taken_o  = lk_hit && lk_ent.cnt[CNT_W-1];
  assign pred_target_o = pred_taken_o ? lk_ent.target : pc_i + ADDR_W'(4);

  // ------------------------------------------------------------ mispredict
  // A not-taken branch has no meaningful target, so only taken ones compare it.
  assign mispredict_o = upd_valid_i &&
                        ((upd_taken_i != upd_pred_taken_i) ||
                         (upd_taken_i && (upd_target_i != upd_pred_target_i)));

  // ---------------------------------------------------------------- update
  logic [IDX_W-1:0] up_idx;
  logic [TAG_W-1:0] up_tag;
  logic             up_hit;

  assign up_idx = upd_pc_i[IDX_W+1:2];
  assign up_tag = upd_pc_i[ADDR_W-1:IDX_W+2];
  assign up_hit = tbl_q[up_idx].valid && (tbl_q[up_idx].tag == up_tag);

  always_comb begin
    for (int i = 0; i < ENTRIES; i++) begin
      tbl_d[i] = tbl_q[i];
    end

    if (clear_i) begin
      // Clear wins over a concurrent update; that update is simply dropped.
      for (int i = 0; i < ENTRIES; i++) begin
        tbl_d[i].valid = 1'b0;
        tbl_d[i].cnt   = CNT_WNT;
      end
    end else if (upd_valid_i) begin
      if (up_hit) begin
        if (upd_taken_i) begin
          tbl_d[up_idx].target = upd_target_i;
          if (tbl_q[up_idx].cnt != CNT_MAX) begin
            tbl_d[up_idx].cnt = tbl_q[up_idx].cnt + CNT_W'(1);
          end
        end else if (tbl_q[up_idx].cnt != '0) begin
          tbl_d[up_idx].cnt = tbl_q[up_idx].cnt - CNT_W'(1);
        end
      end else if (upd_taken_i) begin
        // Allocation evicts whatever alias currently occupies the slot.
        tbl_d[up_idx].valid  = 1'b1;
        tbl_d[up_idx].tag    = up_tag;
        tbl_d[up_idx].target = upd_target_i;
        tbl_d[up_idx].cnt    = CNT_WT;
      end
    end
  end

  // The statistic is independent of clear_i.
  always_comb begin
    mispred_cnt_d = mispred_cnt_q;
    if (mispredict_o && (mispred_cnt_q != STAT_MAX)) begin
      mispred_cnt_d = mispred_cnt_q + STAT_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < ENTRIES; i++) begin
        tbl_q[i].valid  <= 1'b0;
        tbl_q[i].tag    <= '0;
        tbl_q[i].target <= '0;
        tbl_q[i].cnt    <= CNT_WNT;
      end
      mispred_cnt_q <= '0;
    end else begin
      for (int i = 0; i < ENTRIES; i++) begin
        tbl_q[i] <= tbl_d[i];
      end
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  assign mispred_cnt_o = mispred_cnt_q;

endmodule

// File: tb/tb_branch_predictor.sv
module tb_branch_predictor;

  logic        clk;
  logic        rst;
  logic [31:0] lk_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_pred_taken;
  logic [31:0] upd_pred_target;
  logic        mispredict;
  logic        clr;
  logic [3:0]  mispred_cnt;

  branch_predictor #(
    .ADDR_W (32),
    .ENTRIES(16),
    .CNT_W  (2),
    .STAT_W (4)
  ) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .pc_i             (lk_pc),
    .pred_taken_o     (pred_taken),
    .pred_target_o    (pred_target),
    .upd_valid_i      (upd_valid),
    .upd_pc_i         (upd_pc),
    .upd_taken_i      (upd_taken),
    .upd_target_i     (upd_target),
    .upd_pred_taken_i (upd_pred_taken),
    .upd_pred_target_i(upd_pred_target),
    .mispredict_o     (mispredict),
    .clear_i          (clr),
    .mispred_cnt_o    (mispred_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  // Reference model: one slot per word-index modulo 16, tag kept as pc/64.
  bit          m_valid [16];
  int unsigned m_tag   [16];
  int unsigned m_tgt   [16];
  int          m_cnt   [16];
  int          m_stat;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void m_reset();
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 0;
      m_cnt[i]   = 1;
    end
    m_stat = 0;
  endfunction

  function automatic void m_lookup(input logic [31:0] pc, output bit t, output logic [31:0] tgt);
    int idx;
    idx = (pc / 4) % 16;
    t   = m_valid[idx] && (m_tag[idx] == pc / 64) && (m_cnt[idx] >= 2);
    tgt = t ? m_tgt[idx] : pc + 32'd4;
  endfunction

  function automatic bit m_mispredict();
    if (!upd_valid) return 0;
    if (upd_taken != upd_pred_taken) return 1;
    return upd_taken && (upd_target != upd_pred_target);
  endfunction

  function automatic void m_update();
    int idx;
    bit hit;
    if (m_mispredict()) m_stat = (m_stat + 1 > 15) ? 15 : m_stat + 1;
    if (clr) begin
      for (int i = 0; i < 16; i++) begin
        m_valid[i] = 0;
        m_cnt[i]   = 1;
      end
    end else if (upd_valid) begin
      idx = (upd_pc / 4) % 16;
      hit = m_valid[idx] && (m_tag[idx] == upd_pc / 64);
      if (hit && upd_taken) begin
        m_cnt[idx] = (m_cnt[idx] + 1 > 3) ? 3 : m_cnt[idx] + 1;
        m_tgt[idx] = upd_target;
      end else if (hit) begin
        m_cnt[idx] = (m_cnt[idx] - 1 < 0) ? 0 : m_cnt[idx] - 1;
      end else if (upd_taken) begin
        m_valid[idx] = 1;
        m_tag[idx]   = upd_pc / 64;
        m_tgt[idx]   = upd_target;
        m_cnt[idx]   = 2;
      end
    end
  endfunction

  task automatic set_upd(input bit v, input logic [31:0] pc, input bit t, input logic [31:0] tgt,
                         input bit pt, input logic [31:0] ptgt);
    upd_valid       = v;
    upd_pc          = pc;
    upd_taken       = t;
    upd_target      = tgt;
    upd_pred_taken  = pt;
    upd_pred_target = ptgt;
  endtask

  // Update whose carried prediction is what the model predicts for that PC.
  task automatic upd_model(input logic [31:0] pc, input bit t, input logic [31:0] tgt);
    bit          pt;
    logic [31:0] ptgt;
    m_lookup(pc, pt, ptgt);
    set_upd(1, pc, t, tgt, pt, ptgt);
  endtask

  task automatic idle();
    set_upd(0, 32'h0, 0, 32'h0, 0, 32'h0);
  endtask

  // Check all outputs against the model, then take one clock edge.
  task automatic cycle();
    bit          et;
    logic [31:0] etgt;
    #1;
    m_lookup(lk_pc, et, etgt);
    chk("cyc_pred_taken", {31'b0, pred_taken}, {31'b0, et});
    chk("cyc_pred_target", pred_target, etgt);
    chk("cyc_mispredict", {31'b0, mispredict}, {31'b0, m_mispredict()});
    chk("cyc_stat", {28'b0, mispred_cnt}, m_stat);
    @(posedge clk);
    m_update();
    #1;
  endtask

  function automatic logic [31:0] rand_pc();
    return ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
  endfunction

  initial begin
    rst   = 1'b1;
    clr   = 1'b0;
    lk_pc = 32'h0;
    idle();
    m_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state.
    lk_pc = 32'h40;
    #1;
    chk("rst_pred_taken", {31'b0, pred_taken}, 32'h0);
    chk("rst_pred_target", pred_target, 32'h44);
    chk("rst_stat", {28'b0, mispred_cnt}, 32'h0);

    // Allocate 0x40 -> 0x100 with a not-taken prediction.
    set_upd(1, 32'h40, 1, 32'h100, 0, 32'h44);
    #1;
    chk("alloc_mispredict", {31'b0, mispredict}, 32'h1);
    cycle();
    idle();
    #1;
    chk("alloc_pred_taken", {31'b0, pred_taken}, 32'h1);
    chk("alloc_pred_target", pred_target, 32'h100);
    chk("alloc_stat", {28'b0, mispred_cnt}, 32'h1);

    // Counter saturation: up to 3, down to 1, back up and held at 3.
    repeat (3) begin upd_model(32'h40, 1, 32'h100); cycle(); end
    upd_model(32'h40, 0, 32'h0); cycle();
    idle(); #1;
    chk("sat_dec1_taken", {31'b0, pred_taken}, 32'h1);
    upd_model(32'h40, 0, 32'h0); cycle();
    idle(); #1;
    chk("sat_dec2_taken", {31'b0, pred_taken}, 32'h0);
    repeat (4) begin upd_model(32'h40, 1, 32'h100); cycle(); end
    upd_model(32'h40, 0, 32'h0); cycle();
    idle(); #1;
    chk("sat_hold_taken", {31'b0, pred_taken}, 32'h1);
    upd_model(32'h40, 0, 32'h0); cycle();
    idle(); #1;
    chk("sat_hold_dec_taken", {31'b0, pred_taken}, 32'h0);
    repeat (2) begin upd_model(32'h40, 1, 32'h100); cycle(); end

    // Alias eviction: 0x80 shares index 0 with 0x40.
    upd_model(32'h80, 1, 32'h200); cycle();
    idle();
    lk_pc = 32'h40; #1;
    chk("alias_old_taken", {31'b0, pred_taken}, 32'h0);
    chk("alias_old_target", pred_target, 32'h44);
    lk_pc = 32'h80; #1;
    chk("alias_new_taken", {31'b0, pred_taken}, 32'h1);
    chk("alias_new_target", pred_target, 32'h200);

    // Same-cycle lookup sees the pre-update target.
    upd_model(32'h80, 1, 32'h300);
    #1;
    chk("bypass_old_target", pred_target, 32'h200);
    cycle();
    idle(); #1;
    chk("bypass_new_target", pred_target, 32'h300);

    // Clear together with a mispredicting update.
    clr = 1'b1;
    set_upd(1, 32'h40, 1, 32'h500, 0, 32'h44);
    cycle();
    clr = 1'b0;
    idle();
    for (int i = 0; i < 32; i++) begin
      lk_pc = 32'h40 * (i / 16) + 32'h4 * (i % 16);
      #1;
      chk("clear_pred_taken", {31'b0, pred_taken}, 32'h0);
    end
    chk("clear_stat", {28'b0, mispred_cnt}, m_stat);
    cycle();

    // Randomised traffic against the model.
    for (int n = 0; n < 400; n++) begin
      lk_pc = rand_pc();
      if ($urandom_range(0, 1) == 0) begin
        upd_model(rand_pc(), 1'($urandom_range(0, 1)), $urandom & 32'h0000_fffc);
      end else begin
        set_upd(1'($urandom_range(0, 3) != 0), rand_pc(), 1'($urandom_range(0, 1)),
                $urandom & 32'h0000_00fc, 1'($urandom_range(0, 1)), $urandom & 32'h0000_00fc);
      end
      clr = ($urandom_range(0, 39) == 0);
      cycle();
    end
    clr = 1'b0;
    idle();

    // Asynchronous reset in the middle of an update.
    repeat (3) begin upd_model(32'h40, 1, 32'h700); cycle(); end
    idle();
    lk_pc = 32'h40; #1;
    chk("pre_arst_taken", {31'b0, pred_taken}, 32'h1);
    set_upd(1, 32'h40, 1, 32'h900, 0, 32'h44);
    #1 rst = 1'b1;
    #1;
    m_reset();
    chk("arst_pred_taken", {31'b0, pred_taken}, 32'h0);
    chk("arst_pred_target", pred_target, 32'h44);
    chk("arst_stat", {28'b0, mispred_cnt}, 32'h0);
    idle();
    rst = 1'b0;
    cycle();

    // Statistic saturation at 15.
    for (int n = 0; n < 20; n++) begin
      lk_pc = rand_pc();
      set_upd(1, rand_pc(), 1, 32'h1000, 0, 32'h0);
      cycle();
    end
    idle(); #1;
    chk("stat_saturate", {28'b0, mispred_cnt}, 32'd15);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Parametrised branch target buffer with per-entry saturating direction counters, for the 5-stage pipeline CPU. It replaces static "predict not-taken, flush on taken" behaviour. The IF stage looks up the fetch PC in the same cycle and gets a predicted next PC. The ID stage, where branches resolve, reports the real outcome; the block then updates its table, flags a mispredict for the IF/ID flush, and keeps a mispredict statistic.

## Interface
Parameters:
- ADDR_W, 32, PC width in bits.
- ENTRIES, 16, number of BTB entries; must be a power of 2 and ≥2. IDX_W = log2(ENTRIES).
- CNT_W, 2, direction counter width; must be ≥1.
- STAT_W, 16, width of the mispredict statistic counter.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset; asynchronous, active-high.
- pc_i  in  ADDR_W  IF-stage fetch PC for lookup.
- pred_taken_o  out  1  lookup predicts taken.
- pred_target_o  out  ADDR_W  predicted next PC: stored target if pred_taken_o, else pc_i+4.
- upd_valid_i  in  1  ID stage holds a resolved branch or jump this cycle.
- upd_pc_i  in  ADDR_W  PC of that branch.
- upd_taken_i  in  1  actual direction.
- upd_target_i  in  ADDR_W  actual taken target.
- upd_pred_taken_i  in  1  prediction made for this branch in IF, carried down the pipeline.
- upd_pred_target_i  in  ADDR_W  predicted next PC made for this branch in IF.
- mispredict_o  out  1  combinational; feeds the IF/ID flush and PC redirect.
- clear_i  in  1  synchronous invalidate of all entries.
- mispred_cnt_o  out  STAT_W  saturating count of mispredicts since reset.

## Operation
- Entry fields: valid (1 bit), tag (ADDR_W-IDX_W-2 bits), target (ADDR_W bits), cnt (CNT_W bits).
- PC fields: index = pc[IDX_W+1:2]; tag = pc[ADDR_W-1:IDX_W+2]; pc[1:0] is ignored.
- Lookup is combinational. Hit = valid AND tag match.
  - pred_taken_o = hit AND cnt MSB = 1.
  - pred_target_o = pred_taken_o ? target : pc_i+4, computed modulo 2^ADDR_W.
- mispredict_o = upd_valid_i AND (upd_taken_i ≠ upd_pred_taken_i OR (upd_taken_i AND upd_target_i ≠ upd_pred_target_i)). It is 0 whenever upd_valid_i = 0.
- Table update applies only when upd_valid_i = 1 and clear_i = 0:
  - Hit, taken: cnt saturating-increments to max 2^CNT_W-1; target is overwritten with upd_target_i.
  - Hit, not taken: cnt saturating-decrements to min 0; target is unchanged.
  - Miss, taken: the entry is allocated and overwrites any valid alias. valid=1, tag and target loaded, cnt = 2^(CNT_W-1) (weakly taken).
  - Miss, not taken: no change.
- mispred_cnt_o increments by 1 on each clock edge where mispredict_o = 1. It saturates at 2^STAT_W-1. It is not cleared by clear_i.
- clear_i = 1: all valid bits go to 0 and all cnt fields go to 2^(CNT_W-1)-1 (weakly not taken).
  - clear_i beats a simultaneous update; that update is dropped from the table.
  - The mispredict statistic still counts it.
- Reset (asynchronous, any time, including mid-update):
  - All valid bits = 0.
  - All cnt fields = 2^(CNT_W-1)-1.
  - mispred_cnt_o = 0.
  - Target and tag contents are don't-care.

## Timing
- Lookup latency is 0 cycles (combinational from pc_i).
- An update in cycle N is visible to lookups from cycle N+1.
- Lookup and update to the same index in the same cycle: lookup returns the pre-update value. There is no bypass.
- mispredict_o has 0-cycle latency from the upd_* inputs.
- mispred_cnt_o reflects a mispredict in cycle N from cycle N+1.
- Reset values:
  - pred_taken_o = 0.
  - pred_target_o = pc_i+4.
  - mispredict_o is a function of its inputs only.
  - mispred_cnt_o = 0.
- No handshake. upd_valid_i is a single-cycle qualifier, and an update can arrive every cycle.

## Test plan
- Reset, then lookup pc_i=0x40 -> pred_taken_o=0, pred_target_o=0x44, mispred_cnt_o=0.
- Allocate and predict:
  - Stimulus: update pc=0x40, taken, target 0x100, pred_taken=0.
  - Same cycle: mispredict_o=1.
  - Next cycle, lookup 0x40: pred_taken_o=1, pred_target_o=0x100, mispred_cnt_o=1.
- Saturation (CNT_W=2):
  - Stimulus: 3 taken updates at 0x40, then 2 not-taken.
  - After the taken updates: cnt=3. After the first not-taken: cnt=2, still predicted taken. After the second: cnt=1, pred_taken_o=0.
  - Further taken updates leave cnt at 3.
- Alias eviction (ENTRIES=16):
  - Stimulus: 0x40 is allocated; then a taken update at 0x80 (same index, different tag), target 0x200.
  - Result: lookup 0x40 gives pred_taken_o=0 and pred_target_o=0x44; lookup 0x80 gives target 0x200.
- Same-cycle update and lookup at 0x40, then clear_i together with an update:
  - Same-cycle lookup returns the old prediction.
  - After clear, every lookup returns not-taken.
  - mispred_cnt_o still counts the mispredicting update issued with clear.
- Asynchronous reset pulse mid-update:
  - All predictions revert to not-taken immediately; mispred_cnt_o=0 with no clock edge.
  - With STAT_W=4, 20 mispredicts leave mispred_cnt_o at 15.
